move_sequencer: RTL and testbench

- Multi-cycle controller that advances one actor (player or object) by one frame of movement.
- Accumulates sub-pixel speed into the remainder, rounds the result to whole pixels per axis, then steps pixel by pixel, X first and then Y.
- Each candidate position is checked through a shared request/ack port on the tile-collision lookup. An axis stops at the first solid hit; its speed and remainder are then zeroed.
- Sits between the per-frame object update logic and the collision arbiter.

---
 rtl/move_sequencer.sv | 209 ++++++++++++++++++++
 tb/tb_move_sequencer.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/move_sequencer.sv
// Per-frame actor mover: accumulates sub-pixel speed, rounds to pixels,
// then steps X then Y one pixel at a time through the collision port.
module move_sequencer #(
    parameter int MAX_STEP = 8,
    parameter int HIT_X    = 1,
    parameter int HIT_Y    = 3,
    parameter int HIT_W    = 6,
    parameter int HIT_H    = 5
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    input  logic [15:0] pos_x_i,
    input  logic [15:0] pos_y_i,
    input  logic [31:0] rem_x_i,
    input  logic [31:0] rem_y_i,
    input  logic [31:0] spd_x_i,
    input  logic [31:0] spd_y_i,
    output logic        busy_o,
    output logic        done_o,
    output logic [15:0] pos_x_o,
    output logic [15:0] pos_y_o,
    output logic [31:0] rem_x_o,
    output logic [31:0] rem_y_o,
    output logic [31:0] spd_x_o,
    output logic [31:0] spd_y_o,
    output logic        col_req_o,
    output logic [15:0] col_x_o,
    output logic [15:0] col_y_o,
    output logic [3:0]  col_w_o,
    output logic [3:0]  col_h_o,
    input  logic        col_ack_i,
    input  logic        col_solid_i
);

    localparam int CW = $clog2(MAX_STEP + 1);

    typedef enum logic [2:0] {
        IDLE, STEP_X, SETUP_Y, STEP_Y, DONE
    } state_t;

    state_t state_q, state_d;

    logic [15:0]   pos_x_q, pos_x_d, pos_y_q, pos_y_d;
    logic [31:0]   rem_x_q, rem_x_d, rem_y_q, rem_y_d;
    logic [31:0]   spd_x_q, spd_x_d, spd_y_q, spd_y_d;
    logic          neg_x_q, neg_x_d, neg_y_q, neg_y_d;
    logic [CW-1:0] cnt_q, cnt_d, cnt_y_q, cnt_y_d;
    logic          gap_q, gap_d;
    logic          load_out;

    logic [31:0] r_x, r_y, amt_x, amt_y;
    logic [15:0] n_x, n_y;

    function automatic logic [CW-1:0] clamp(input logic [15:0] n);
        logic [16:0] mag;
        mag = n[15] ? (17'd0 - {1'b1, n}) : {1'b0, n};
        if (mag > 17'(MAX_STEP))
            return CW'(MAX_STEP);
        return mag[CW-1:0];
    endfunction

    function automatic logic [15:0] unit(input logic neg);
        return neg ? 16'hFFFF : 16'h0001;
    endfunction

    assign r_x   = rem_x_i + spd_x_i;
    assign r_y   = rem_y_i + spd_y_i;
    assign amt_x = (r_x + 32'h8000) & 32'hFFFF_0000;
    assign amt_y = (r_y + 32'h8000) & 32'hFFFF_0000;
    assign n_x   = amt_x[31:16];
    assign n_y   = amt_y[31:16];

    assign busy_o  = state_q inside {STEP_X, SETUP_Y, STEP_Y};
    assign done_o  = (state_q == DONE);
    assign col_w_o = 4'(HIT_W);
    assign col_h_o = 4'(HIT_H);
    assign col_x_o = pos_x_q + 16'(HIT_X)
                   + ((state_q == STEP_X) ? unit(neg_x_q) : 16'h0);
    assign col_y_o = pos_y_q + 16'(HIT_Y)
                   + ((state_q == STEP_Y) ? unit(neg_y_q) : 16'h0);

    always_comb begin
        state_d   = state_q;
        pos_x_d   = pos_x_q;
        pos_y_d   = pos_y_q;
        rem_x_d   = rem_x_q;
        rem_y_d   = rem_y_q;
        spd_x_d   = spd_x_q;
        spd_y_d   = spd_y_q;
        neg_x_d   = neg_x_q;
        neg_y_d   = neg_y_q;
        cnt_d     = cnt_q;
        cnt_y_d   = cnt_y_q;
        gap_d     = gap_q;
        col_req_o = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start_i) begin
                    pos_x_d = pos_x_i;
                    pos_y_d = pos_y_i;
                    rem_x_d = r_x - amt_x;
                    rem_y_d = r_y - amt_y;
                    spd_x_d = spd_x_i;
                    spd_y_d = spd_y_i;
                    neg_x_d = n_x[15];
                    neg_y_d = n_y[15];
                    cnt_d   = clamp(n_x);
                    cnt_y_d = clamp(n_y);
                    gap_d   = 1'b0;
                    state_d = STEP_X;
                end
            end
            STEP_X: begin
                if (cnt_q == '0) begin
                    state_d = SETUP_Y;
                end else if (gap_q) begin
                    gap_d = 1'b0;
                end else begin
                    col_req_o = 1'b1;
                    if (col_ack_i && col_solid_i) begin
                        spd_x_d = '0;
                        rem_x_d = '0;
                        cnt_d   = '0;
                        state_d = SETUP_Y;
                    end else if (col_ack_i) begin
                        pos_x_d = pos_x_q + unit(neg_x_q);
                        cnt_d   = cnt_q - 1'b1;
                        gap_d   = 1'b1;
                    end
                end
            end
            SETUP_Y: begin
                cnt_d   = cnt_y_q;
                gap_d   = 1'b0;
                state_d = STEP_Y;
            end
            STEP_Y: begin
                if (cnt_q == '0) begin
                    state_d = DONE;
                end else if (gap_q) begin
                    gap_d = 1'b0;
                end else begin
                    col_req_o = 1'b1;
                    if (col_ack_i && col_solid_i) begin
                        spd_y_d = '0;
                        rem_y_d = '0;
                        cnt_d   = '0;
                        state_d = DONE;
                    end else if (col_ack_i) begin
                        pos_y_d = pos_y_q + unit(neg_y_q);
                        cnt_d   = cnt_q - 1'b1;
                        gap_d   = 1'b1;
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Result registers capture the final values on entry to DONE
    assign load_out = (state_q == STEP_Y) && (state_d == DONE);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            pos_x_q <= '0;
            pos_y_q <= '0;
            rem_x_q <= '0;
            rem_y_q <= '0;
            spd_x_q <= '0;
            spd_y_q <= '0;
            neg_x_q <= 1'b0;
            neg_y_q <= 1'b0;
            cnt_q   <= '0;
            cnt_y_q <= '0;
            gap_q   <= 1'b0;
            pos_x_o <= '0;
            pos_y_o <= '0;
            rem_x_o <= '0;
            rem_y_o <= '0;
            spd_x_o <= '0;
            spd_y_o <= '0;
        end else begin
            state_q <= state_d;
            pos_x_q <= pos_x_d;
            pos_y_q <= pos_y_d;
            rem_x_q <= rem_x_d;
            rem_y_q <= rem_y_d;
            spd_x_q <= spd_x_d;
            spd_y_q <= spd_y_d;
            neg_x_q <= neg_x_d;
            neg_y_q <= neg_y_d;
            cnt_q   <= cnt_d;
            cnt_y_q <= cnt_y_d;
            gap_q   <= gap_d;
            if (load_out) begin
                pos_x_o <= pos_x_d;
                pos_y_o <= pos_y_d;
                rem_x_o <= rem_x_d;
                rem_y_o <= rem_y_d;
                spd_x_o <= spd_x_d;
                spd_y_o <= spd_y_d;
            end
        end
    end

endmodule

// File: tb/tb_move_sequencer.sv
// Scoreboard bench for move_sequencer: a collision responder with random
// ack latency, a behavioural move model, and a done-triggered monitor.
module tb_move_sequencer;

    localparam int MAX_STEP = 8;
    localparam int HIT_X    = 1;
    localparam int HIT_Y    = 3;
    localparam int HIT_W    = 6;
    localparam int HIT_H    = 5;

    logic        clk = 0;
    logic        rst_i = 1;
    logic        start_i = 0;
    logic [15:0] pos_x_i = 0, pos_y_i = 0;
    logic [31:0] rem_x_i = 0, rem_y_i = 0;
    logic [31:0] spd_x_i = 0, spd_y_i = 0;
    logic        busy_o, done_o;
    logic [15:0] pos_x_o, pos_y_o;
    logic [31:0] rem_x_o, rem_y_o, spd_x_o, spd_y_o;
    logic        col_req_o;
    logic [15:0] col_x_o, col_y_o;
    logic [3:0]  col_w_o, col_h_o;
    logic        col_ack_i = 0, col_solid_i = 0;

    move_sequencer #(
        .MAX_STEP(MAX_STEP), .HIT_X(HIT_X), .HIT_Y(HIT_Y),
        .HIT_W(HIT_W), .HIT_H(HIT_H)
    ) dut (
        .clk_i(clk), .rst_i(rst_i), .start_i(start_i),
        .pos_x_i(pos_x_i), .pos_y_i(pos_y_i),
        .rem_x_i(rem_x_i), .rem_y_i(rem_y_i),
        .spd_x_i(spd_x_i), .spd_y_i(spd_y_i),
        .busy_o(busy_o), .done_o(done_o),
        .pos_x_o(pos_x_o), .pos_y_o(pos_y_o),
        .rem_x_o(rem_x_o), .rem_y_o(rem_y_o),
        .spd_x_o(spd_x_o), .spd_y_o(spd_y_o),
        .col_req_o(col_req_o), .col_x_o(col_x_o), .col_y_o(col_y_o),
        .col_w_o(col_w_o), .col_h_o(col_h_o),
        .col_ack_i(col_ack_i), .col_solid_i(col_solid_i)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [15:0] px, py;
        logic [31:0] rx, ry, sx, sy;
        int          lat;
    } res_t;

    res_t        rexp[$];
    logic [31:0] qexp[$];

    int          n_checks = 0, n_fail = 0;
    int          done_cnt = 0, start_cyc = 0;
    int          wall_x = -1, density = 0;
    int unsigned seed = 32'h1234;
    int          lat_lo = 0, lat_hi = 0;
    bit          resp_en = 1;

    task automatic fail(input string nm, input logic [63:0] act,
                        input logic [63:0] req);
        n_fail++;
        $display("FAIL %s: actual=%0h required=%0h (t=%0t)", nm, act, req, $time);
    endtask

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] req);
        n_checks++;
        if (act !== req) fail(nm, act, req);
    endtask

    // Tile world: an optional solid column plus hashed random solids
    function automatic bit is_solid(input logic [15:0] x, input logic [15:0] y);
        int unsigned h;
        if (wall_x >= 0 && int'(x) == wall_x) return 1'b1;
        h = ({16'h0, x} * 32'd2654435761) ^ ({16'h0, y} * 32'd40503) ^ seed;
        return int'((h >> 16) & 32'hFF) < density;
    endfunction

    // Round rem+spd to the nearest pixel (half up), keep the fraction
    task automatic split(input logic [31:0] rem, input logic [31:0] spd,
                         output logic [31:0] nrem, output int steps,
                         output bit neg);
        logic [31:0] rr;
        longint      r, t, n;
        logic [15:0] nw;
        int          ns;
        rr   = rem + spd;
        r    = longint'($signed(rr));
        t    = r + 32768;
        n    = (t >= 0) ? t / 65536 : -((-t + 65535) / 65536);
        nrem = 32'(r - n * 65536);
        nw   = 16'(n);
        ns   = int'($signed(nw));
        neg  = ns < 0;
        steps = neg ? -ns : ns;
        if (steps > MAX_STEP) steps = MAX_STEP;
    endtask

    task automatic model(input logic [15:0] px0, input logic [15:0] py0,
                         input logic [31:0] rx0, input logic [31:0] ry0,
                         input logic [31:0] sx0, input logic [31:0] sy0,
                         output res_t r);
        logic [15:0] px, py, c, qx, qy;
        logic [31:0] rx, ry, sx, sy;
        int          nx, ny, nq;
        bit          negx, negy;
        split(rx0, sx0, rx, nx, negx);
        split(ry0, sy0, ry, ny, negy);
        px = px0; py = py0; sx = sx0; sy = sy0; nq = 0;
        for (int i = 0; i < nx; i++) begin
            c  = negx ? px - 16'd1 : px + 16'd1;
            qx = c + 16'(HIT_X);
            qy = py + 16'(HIT_Y);
            qexp.push_back({qx, qy});
            nq++;
            if (is_solid(qx, qy)) begin
                sx = 0; rx = 0;
                break;
            end
            px = c;
        end
        for (int i = 0; i < ny; i++) begin
            c  = negy ? py - 16'd1 : py + 16'd1;
            qx = px + 16'(HIT_X);
            qy = c + 16'(HIT_Y);
            qexp.push_back({qx, qy});
            nq++;
            if (is_solid(qx, qy)) begin
                sy = 0; ry = 0;
                break;
            end
            py = c;
        end
        r = '{px, py, rx, ry, sx, sy, (nq == 0) ? 4 : -1};
    endtask

    always @(negedge clk) begin : monitor
        res_t e;
        if (!rst_i && done_o) begin
            if (rexp.size() == 0) begin
                n_checks++;
                fail("unexpected_done", 1, 0);
            end else begin
                e = rexp.pop_front();
                chk("pos_x", pos_x_o, e.px);
                chk("pos_y", pos_y_o, e.py);
                chk("rem_x", rem_x_o, e.rx);
                chk("rem_y", rem_y_o, e.ry);
                chk("spd_x", spd_x_o, e.sx);
                chk("spd_y", spd_y_o, e.sy);
                chk("busy_at_done", busy_o, 0);
                if (e.lat >= 0) chk("latency", cyc - start_cyc, e.lat);
                chk("queries_left", qexp.size(), 0);
            end
            done_cnt++;
        end
    end

    initial begin : responder
        logic [15:0] qx, qy;
        logic [31:0] e;
        int          l;
        forever begin
            @(negedge clk);
            if (resp_en) begin
                col_ack_i   = 0;
                col_solid_i = 0;
            end
            if (resp_en && !rst_i && col_req_o) begin
                qx = col_x_o;
                qy = col_y_o;
                chk("hitbox", {col_w_o, col_h_o}, {4'(HIT_W), 4'(HIT_H)});
                if (qexp.size() == 0) begin
                    n_checks++;
                    fail("unexpected_query", {qx, qy}, 0);
                end else begin
                    e = qexp.pop_front();
                    chk("query_xy", {qx, qy}, e);
                end
                l = $urandom_range(lat_hi, lat_lo);
                repeat (l) begin
                    @(negedge clk);
                    chk("req_hold", col_req_o, 1);
                    chk("query_hold", {col_x_o, col_y_o}, {qx, qy});
                end
                col_ack_i   = 1;
                col_solid_i = is_solid(qx, qy);
                @(negedge clk);
                col_ack_i   = 0;
                col_solid_i = 0;
                chk("req_gap", col_req_o, 0);
            end else if (resp_en && !col_req_o && $urandom_range(0, 7) == 0) begin
                col_ack_i   = 1;
                col_solid_i = 1;
            end
        end
    end

    task automatic run_txn(input logic [15:0] px, input logic [15:0] py,
                           input logic [31:0] rx, input logic [31:0] ry,
                           input logic [31:0] sx, input logic [31:0] sy,
                           input bit poke);
        res_t r;
        int   d0, t;
        @(negedge clk);
        pos_x_i = px; pos_y_i = py;
        rem_x_i = rx; rem_y_i = ry;
        spd_x_i = sx; spd_y_i = sy;
        model(px, py, rx, ry, sx, sy, r);
        rexp.push_back(r);
        d0 = done_cnt;
        start_i = 1;
        start_cyc = cyc;
        @(negedge clk);
        start_i = 0;
        chk("busy_after_start", busy_o, 1);
        if (poke) begin
            pos_x_i = 16'($urandom);
            spd_x_i = $urandom;
            spd_y_i = $urandom;
            start_i = 1;
            @(negedge clk);
            start_i = 0;
        end
        t = 0;
        while (done_cnt == d0 && t < 3000) begin
            @(negedge clk);
            t++;
        end
        if (done_cnt == d0) begin
            n_checks++;
            fail("done_timeout", t, 3000);
            rexp.delete();
            qexp.delete();
        end
    endtask

    initial begin : main
        int          t;
        logic [31:0] sx, sy, rx, ry;
        repeat (3) @(negedge clk);
        chk("rst_busy", busy_o, 0);
        chk("rst_done", done_o, 0);
        chk("rst_req", col_req_o, 0);
        chk("rst_pos", {pos_x_o, pos_y_o}, 0);
        chk("rst_rem", {rem_x_o, rem_y_o}, 0);
        chk("rst_spd", {spd_x_o, spd_y_o}, 0);
        rst_i = 0;

        lat_lo = 0; lat_hi = 0; density = 0; wall_x = -1;
        run_txn(10, 20, 0, 0, 0, 0, 0);
        run_txn(10, 20, 0, 0, 32'h0002_8000, 0, 0);
        wall_x = 13;
        run_txn(10, 20, 0, 0, 32'h0003_0000, 32'h0002_0000, 0);
        wall_x = -1;
        run_txn(10, 20, 0, 0, 32'hFFFE_C000, 0, 0);
        run_txn(10, 20, 0, 0, 0, 32'h0014_0000, 0);
        lat_lo = 3; lat_hi = 3;
        run_txn(10, 20, 0, 0, 32'h0002_0000, 32'hFFFE_0000, 1);
        run_txn(16'hFFFE, 16'h7FFF, 0, 0, 32'h0005_0000, 32'h0003_0000, 0);

        lat_lo = 0; lat_hi = 3;
        for (int i = 0; i < 40; i++) begin
            density = $urandom_range(0, 90);
            seed    = $urandom;
            sx = $urandom_range(0, 24 * 65536) - 12 * 65536;
            sy = $urandom_range(0, 24 * 65536) - 12 * 65536;
            rx = $urandom_range(0, 65535) - 32768;
            ry = $urandom_range(0, 65535) - 32768;
            if (i % 8 == 7) begin
                sx = $urandom; sy = $urandom;
                rx = $urandom; ry = $urandom;
            end
            run_txn(16'($urandom), 16'($urandom), rx, ry, sx, sy,
                    1'($urandom_range(0, 1)));
        end

        // Abandon a move mid-Y with a reset, then feed a stale ack
        density = 0; wall_x = -1;
        resp_en = 0;
        col_ack_i = 0; col_solid_i = 0;
        @(negedge clk);
        pos_x_i = 0; pos_y_i = 0;
        rem_x_i = 0; rem_y_i = 0;
        spd_x_i = 0; spd_y_i = 32'h0003_0000;
        start_i = 1;
        @(negedge clk);
        start_i = 0;
        t = 0;
        while (!col_req_o && t < 50) begin
            @(negedge clk);
            t++;
        end
        chk("y_req_seen", col_req_o, 1);
        rst_i = 1;
        @(negedge clk);
        rst_i = 0;
        chk("midrst_busy", busy_o, 0);
        chk("midrst_done", done_o, 0);
        chk("midrst_req", col_req_o, 0);
        chk("midrst_pos", {pos_x_o, pos_y_o}, 0);
        chk("midrst_rem", {rem_x_o, rem_y_o}, 0);
        chk("midrst_spd", {spd_x_o, spd_y_o}, 0);
        col_ack_i = 1; col_solid_i = 1;
        @(negedge clk);
        col_ack_i = 0; col_solid_i = 0;
        chk("late_ack_busy", busy_o, 0);
        chk("late_ack_req", col_req_o, 0);
        resp_en = 1;

        density = 40; seed = 32'hBEEF;
        run_txn(100, 200, 32'h0000_4000, 0, 32'h0001_8000, 32'hFFFF_0000, 0);
        repeat (3) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
